cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step sequencer placed between a debug host and the `cpu` top.
- Decides on which `clk` edges the CPU advances (`cpu_clk_en`).
- Halts the CPU on a microcode `brk`.
- Pulses the control-logic reset (`crstn`).
- Hands the CPU buses to the host by dropping `ctrlen`, so the CPU's control word stops driving them.

It is the single owner of CPU execution state. The host issues commands over a valid/ready port.

## Interface
Parameters:
- `CNT_W`, 16: width of the run-for-N-cycles argument and down-counter.
- `RST_CYCLES`, 2: number of cycles `crstn` is held low after reset or a RESET command (must be ≥1).

Ports:
- `clk`, in, 1: the single clock for this block.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: command accept. A command is accepted when `cmd_valid & cmd_ready` at a `clk` edge.
- `cmd_op`, in, 3: command opcode.
  - 0 NOP, 1 RUN, 2 HALT, 3 STEP (one cycle), 4 STEPI (one instruction), 5 RUNN (run N cycles), 6 RESET (control-logic reset). Opcode 7 is treated as NOP.
- `cmd_arg`, in, CNT_W: N for RUNN.
- `brk`, in, 1: break bit of the current control word.
- `step_reset`, in, 1: high in the last micro-step of an instruction.
- `bus_req`, in, 1: host requests `main_bus`/`addr_bus`.
- `bus_gnt`, out, 1: host owns the buses.
- `cpu_clk_en`, out, 1: the CPU advances on this `clk` edge.
- `ctrlen`, out, 1: CPU control-word output enable.
- `crstn`, out, 1: active-low control-logic reset.
- `halted`, out, 1: block is in IDLE.
- `brk_hit`, out, 1: sticky flag, set when the last run stopped on `brk`.
- `cyc_count`, out, 32: count of enabled CPU cycles.

## Operation
States: CRST, IDLE, RUN, RUNN, STEP, STEPI, DRAIN, GRANT.

- **Moore outputs:**
  - `cpu_clk_en` = state ∈ {RUN, RUNN, STEP, STEPI}.
  - `ctrlen` = state ∉ {DRAIN, GRANT}.
  - `bus_gnt` = (state == GRANT).
  - `crstn` = ~(rst | state == CRST).
  - `halted` = (state == IDLE).
- **Reset:** state = CRST with its counter loaded to RST_CYCLES; `brk_hit` = 0; `cyc_count` = 0. While `rst` is high: `cpu_clk_en` 0, `ctrlen` 1, `bus_gnt` 0, `crstn` 0.
- **CRST:** counts down RST_CYCLES cycles, then goes to IDLE. `cmd_ready` = 0.
- **IDLE:**
  - If `bus_req` is high, go to DRAIN; `bus_req` has priority over commands. `cmd_ready` = ~`bus_req`.
  - Accepted commands:
    - RUN → RUN.
    - STEP → STEP.
    - STEPI → STEPI.
    - RUNN → RUNN with the counter loaded to `cmd_arg`. If `cmd_arg` = 0, stay in IDLE.
    - RESET → CRST, and clear `cyc_count`.
    - NOP/HALT → no effect.
  - Any accepted command other than NOP clears `brk_hit`.
- **Running states (RUN, RUNN, STEP, STEPI):** `cmd_ready` = (`cmd_op` == HALT). An accepted HALT goes to IDLE. The cycle in which HALT is accepted is still enabled.
- **Exit conditions** (evaluated per enabled cycle, the cycle itself executes):
  - STEP: always, after exactly one cycle.
  - STEPI: when `step_reset` = 1.
  - RUNN: when the counter = 1. Otherwise the counter decrements.
  - RUN/RUNN/STEPI: when `brk` = 1. This sets `brk_hit`.
  - Simultaneous exit conditions all go to IDLE. `brk_hit` is set if `brk` was high.
- **`brk` scope:** `brk` and `step_reset` are ignored when `cpu_clk_en` = 0. STEP never sets `brk_hit`.
- **DRAIN:** one cycle with `ctrlen` = 0 and `bus_gnt` = 0, then GRANT. If `bus_req` has dropped, go straight to IDLE.
- **GRANT:** hold while `bus_req` is high. When `bus_req` is low, go to IDLE; `ctrlen` rises on that same edge. The host is never granted while the CPU is running; it must HALT first.
- **`cyc_count`:** +1 on every edge with `cpu_clk_en` = 1. Wraps modulo 2^32.

## Timing
- All state changes happen on rising `clk` edges. Outputs are decodes of registered state, so there is no combinational path from inputs to outputs except `cmd_ready` (depends on `cmd_op`, `bus_req`) and `crstn` (depends on `rst`).
- **Command latency:**
  - Accept edge → `cpu_clk_en` high in the next cycle.
  - STEP gives exactly one enabled cycle.
  - RUNN N gives exactly N enabled cycles.
- **Break latency:** a `brk` cycle is executed. `cpu_clk_en` is low from the following cycle.
- **Bus handover:**
  - `bus_req` sampled high in IDLE → `ctrlen` low after 1 edge → `bus_gnt` high after 2 edges.
  - Release: `bus_gnt` and `ctrlen` restore on the edge after `bus_req` is sampled low.
- **Async reset mid-operation:** abandons any state immediately. No partial step is counted for an edge at which `rst` is high.

## Test plan
- Reset release: `crstn` low for exactly 2 cycles (RST_CYCLES = 2), then `halted` = 1, `ctrlen` = 1, `cyc_count` = 0.
- RUNN, `cmd_arg` = 5 → exactly 5 cycles of `cpu_clk_en`, `cyc_count` = 5, then `halted`. RUNN with `cmd_arg` = 0 → 0 cycles.
- STEPI with `step_reset` high on the 4th enabled cycle → 4 enabled cycles. STEP → exactly 1.
- RUN with `brk` pulsed on the 10th enabled cycle → 10 enabled cycles, `brk_hit` = 1. The next RUN clears `brk_hit`.
- `bus_req` and `cmd_valid`(RUN) asserted together in IDLE → `cmd_ready` = 0, `ctrlen` low at +1, `bus_gnt` high at +2. Dropping `bus_req` → `ctrlen` high, then RUN accepted.
- `rst` asserted mid-RUN → `cpu_clk_en` drops asynchronously. After release, CRST sequence again and `cyc_count` = 0.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Host command and bus-handover port for cpu_run_ctrl.
//   cmd_valid/cmd_ready : command handshake, accepted when both are high at a clk edge
//   cmd_op              : opcode (NOP, RUN, HALT, STEP, STEPI, RUNN, RESET)
//   cmd_arg             : cycle count for RUNN
//   bus_req/bus_gnt     : host request for main_bus/addr_bus, and the grant back
// master = debug host side, slave = cpu_run_ctrl side.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             bus_req;
  logic             bus_gnt;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, bus_req,
    input  cmd_ready, bus_gnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, bus_req,
    output cmd_ready, bus_gnt
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer between the debug host and the cpu top. Decides which clk
// edges the CPU advances on, halts on a microcode brk, pulses the control-logic
// reset and hands the CPU buses to the host.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   host          : command handshake and bus request/grant (cpu_run_ctrl_if.slave)
//   brk           : break bit of the current control word
//   step_reset    : last micro-step of the current instruction
//   cpu_clk_en    : CPU advances on this edge
//   ctrlen        : CPU control-word output enable
//   crstn         : active-low control-logic reset
//   halted        : sequencer is idle
//   brk_hit       : last run stopped on brk (sticky until the next command)
//   cyc_count     : number of enabled CPU cycles, wraps
//
// state | meaning
// CRST  | control logic held in reset, counter times RST_CYCLES
// IDLE  | CPU stopped, host commands accepted
// RUN   | free running until HALT or brk
// RUNN  | running for the loaded number of cycles
// STEP  | exactly one enabled cycle
// STEPI | running until the last micro-step of the instruction
// DRAIN | control word released from the buses, grant not yet given
// GRANT | host owns the buses
module cpu_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  cpu_run_ctrl_if.slave host,
  input  logic          brk,
  input  logic          step_reset,
  output logic          cpu_clk_en,
  output logic          ctrlen,
  output logic          crstn,
  output logic          halted,
  output logic          brk_hit,
  output logic [31:0]   cyc_count
);

  localparam logic [2:0] S_CRST  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_RUNN  = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;
  localparam logic [2:0] S_STEPI = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_GRANT = 3'd7;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RUN   = 3'd1;
  localparam logic [2:0] OP_HALT  = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_STEPI = 3'd4;
  localparam logic [2:0] OP_RUNN  = 3'd5;
  localparam logic [2:0] OP_RESET = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brk_hit_q, brk_hit_d;
  logic [31:0]      cyc_count_q, cyc_count_d;
  logic             cmd_ready;
  logic             cmd_acc;
  logic             running;

  assign running     = (state_q == S_RUN) || (state_q == S_RUNN) ||
                       (state_q == S_STEP) || (state_q == S_STEPI);
  assign cpu_clk_en  = running;
  assign ctrlen      = (state_q != S_DRAIN) && (state_q != S_GRANT);
  assign host.bus_gnt = (state_q == S_GRANT);
  assign crstn       = ~(rst | (state_q == S_CRST));
  assign halted      = (state_q == S_IDLE);
  assign brk_hit     = brk_hit_q;
  assign cyc_count   = cyc_count_q;

  // Only cmd_ready looks at inputs combinationally; while running the port
  // accepts nothing but HALT so other commands simply wait.
  always_comb begin
    cmd_ready = 1'b0;
    if (state_q == S_IDLE) cmd_ready = ~host.bus_req;
    else if (running)      cmd_ready = (host.cmd_op == OP_HALT);
  end
  assign host.cmd_ready = cmd_ready;
  assign cmd_acc        = host.cmd_valid & cmd_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    brk_hit_d   = brk_hit_q;
    cyc_count_d = cyc_count_q + {31'd0, running};
    case (state_q)
      S_CRST: begin
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      S_IDLE: begin
        if (host.bus_req) begin
          state_d = S_DRAIN;
        end else if (cmd_acc) begin
          if (host.cmd_op != OP_NOP && host.cmd_op != OP_RSVD) brk_hit_d = 1'b0;
          case (host.cmd_op)
            OP_RUN:   state_d = S_RUN;
            OP_STEP:  state_d = S_STEP;
            OP_STEPI: state_d = S_STEPI;
            OP_RUNN: begin
              if (host.cmd_arg != '0) begin
                state_d = S_RUNN;
                cnt_d   = host.cmd_arg;
              end
            end
            OP_RESET: begin
              state_d     = S_CRST;
              cnt_d       = RST_LOAD;
              cyc_count_d = 32'd0;
            end
            default: ;
          endcase
        end
      end
      S_RUN, S_RUNN, S_STEP, S_STEPI: begin
        // STEP ignores brk entirely; the other running states stop on it.
        if (brk && state_q != S_STEP) begin
          brk_hit_d = 1'b1;
          state_d   = S_IDLE;
        end
        if (state_q == S_STEP)                      state_d = S_IDLE;
        if (state_q == S_STEPI && step_reset)       state_d = S_IDLE;
        if (state_q == S_RUNN) begin
          if (cnt_q == CNT_ONE) state_d = S_IDLE;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
        if (cmd_acc) state_d = S_IDLE;
      end
      S_DRAIN: state_d = host.bus_req ? S_GRANT : S_IDLE;
      S_GRANT: state_d = host.bus_req ? S_GRANT : S_IDLE;
      default: state_d = S_CRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CRST;
      cnt_q       <= RST_LOAD;
      brk_hit_q   <= 1'b0;
      cyc_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      brk_hit_q   <= brk_hit_d;
      cyc_count_q <= cyc_count_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        brk = 1'b0;
  logic        step_reset = 1'b0;
  logic        cpu_clk_en, ctrlen, crstn, halted, brk_hit;
  logic [31:0] cyc_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  longint exp_cyc = 0;

  cpu_run_ctrl_if #(.CNT_W(CNT_W)) host_if ();

  cpu_run_ctrl #(.CNT_W(CNT_W), .RST_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host_if),
    .brk        (brk),
    .step_reset (step_reset),
    .cpu_clk_en (cpu_clk_en),
    .ctrlen     (ctrlen),
    .crstn      (crstn),
    .halted     (halted),
    .brk_hit    (brk_hit),
    .cyc_count  (cyc_count)
  );

  always #5 clk = ~clk;

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts the cycles crstn is low, checking nothing is accepted meanwhile.
  task automatic wait_crst(output int n);
    n = 0;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = 3'd1;
    while (!crstn && n < 20) begin
      n++;
      #1;
      n_checks++;
      if (host_if.cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL crst_ready: got %b expected 0", host_if.cmd_ready);
      end
      @(posedge clk); #1;
    end
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 3'd0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] arg);
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_arg   = arg;
    #1;
    chk("issue_ready", {31'd0, host_if.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 3'd0;
  endtask

  // Counts enabled cycles, pulsing brk / step_reset / HALT on the given
  // 1-based enabled cycle (0 = never); pops the expected length and checks.
  task automatic run_and_check(input string name, input int brk_at,
                               input int sr_at, input int halt_at);
    int n;
    int exp_n;
    n = 0;
    while (cpu_clk_en === 1'b1 && n < 100) begin
      n++;
      brk        = (n == brk_at);
      step_reset = (n == sr_at);
      if (n == halt_at) begin
        host_if.cmd_valid = 1'b1;
        host_if.cmd_op    = 3'd2;
        #1;
        chk("halt_ready", {31'd0, host_if.cmd_ready}, 32'd1);
      end
      @(posedge clk); #1;
      brk = 1'b0;
      step_reset = 1'b0;
      host_if.cmd_valid = 1'b0;
      host_if.cmd_op    = 3'd0;
    end
    if (n >= 100) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d enabled cycles expected bounded run", name, n);
    end
    exp_n = exp_q.pop_front();
    exp_cyc += exp_n;
    chk({name, "_len"}, n, exp_n);
    chk({name, "_cyc"}, cyc_count, 32'(exp_cyc));
    chk({name, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    next(); next();
    chk("rst_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    chk("rst_ctrlen", {31'd0, ctrlen}, 32'd1);
    chk("rst_bus_gnt", {31'd0, host_if.bus_gnt}, 32'd0);
    chk("rst_crstn", {31'd0, crstn}, 32'd0);
    rst = 1'b0;
    #1;
    wait_crst(n);
    chk("crst_len", n, 32'd2);
    chk("post_rst_halted", {31'd0, halted}, 32'd1);
    chk("post_rst_ctrlen", {31'd0, ctrlen}, 32'd1);
    chk("post_rst_cyc", cyc_count, 32'd0);
    chk("post_rst_brk_hit", {31'd0, brk_hit}, 32'd0);
    exp_cyc = 0;
  endtask

  task automatic test_runn();
    exp_q.push_back(5);
    issue(3'd5, 16'd5);
    run_and_check("runn5", 0, 0, 0);
    exp_q.push_back(0);
    issue(3'd5, 16'd0);
    chk("runn0_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    run_and_check("runn0", 0, 0, 0);
    exp_q.push_back(1);
    issue(3'd5, 16'd1);
    run_and_check("runn1", 0, 0, 0);
  endtask

  task automatic test_step();
    exp_q.push_back(4);
    issue(3'd4, 16'd0);
    run_and_check("stepi", 0, 4, 0);
    chk("stepi_brk_hit", {31'd0, brk_hit}, 32'd0);
    exp_q.push_back(1);
    issue(3'd3, 16'd0);
    run_and_check("step", 0, 0, 0);
  endtask

  task automatic test_brk();
    exp_q.push_back(10);
    issue(3'd1, 16'd0);
    run_and_check("run_brk", 10, 0, 0);
    chk("run_brk_hit", {31'd0, brk_hit}, 32'd1);
    exp_q.push_back(3);
    issue(3'd1, 16'd0);
    chk("run_clears_brk", {31'd0, brk_hit}, 32'd0);
    run_and_check("run_halt", 0, 0, 3);
    // brk coinciding with the instruction end still reports the break
    exp_q.push_back(2);
    issue(3'd4, 16'd0);
    run_and_check("stepi_brk", 2, 2, 0);
    chk("stepi_brk_hit", {31'd0, brk_hit}, 32'd1);
    // STEP clears brk_hit and never sets it
    exp_q.push_back(1);
    issue(3'd3, 16'd0);
    run_and_check("step_brk", 1, 0, 0);
    chk("step_brk_hit", {31'd0, brk_hit}, 32'd0);
    exp_q.push_back(3);
    issue(3'd5, 16'd7);
    run_and_check("runn_brk", 3, 0, 0);
    chk("runn_brk_hit", {31'd0, brk_hit}, 32'd1);
  endtask

  task automatic test_bus();
    host_if.bus_req   = 1'b1;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = 3'd1;
    #1;
    chk("bus_ready", {31'd0, host_if.cmd_ready}, 32'd0);
    next();
    chk("drain_ctrlen", {31'd0, ctrlen}, 32'd0);
    chk("drain_gnt", {31'd0, host_if.bus_gnt}, 32'd0);
    chk("drain_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    next();
    chk("grant_gnt", {31'd0, host_if.bus_gnt}, 32'd1);
    chk("grant_ctrlen", {31'd0, ctrlen}, 32'd0);
    next();
    chk("grant_hold", {31'd0, host_if.bus_gnt}, 32'd1);
    host_if.bus_req = 1'b0;
    next();
    chk("release_ctrlen", {31'd0, ctrlen}, 32'd1);
    chk("release_gnt", {31'd0, host_if.bus_gnt}, 32'd0);
    #1;
    chk("release_ready", {31'd0, host_if.cmd_ready}, 32'd1);
    next();
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 3'd0;
    exp_q.push_back(2);
    run_and_check("bus_run", 0, 0, 2);
    // a one-cycle request only drains, then returns to idle
    host_if.bus_req = 1'b1;
    next();
    host_if.bus_req = 1'b0;
    chk("short_drain_ctrlen", {31'd0, ctrlen}, 32'd0);
    next();
    chk("short_ctrlen", {31'd0, ctrlen}, 32'd1);
    chk("short_gnt", {31'd0, host_if.bus_gnt}, 32'd0);
    chk("short_halted", {31'd0, halted}, 32'd1);
  endtask

  task automatic test_reset_cmd();
    int n;
    issue(3'd6, 16'd0);
    wait_crst(n);
    chk("reset_cmd_len", n, 32'd2);
    chk("reset_cmd_cyc", cyc_count, 32'd0);
    chk("reset_cmd_halted", {31'd0, halted}, 32'd1);
    exp_cyc = 0;
  endtask

  task automatic test_rst_mid_run();
    int n;
    issue(3'd1, 16'd0);
    next(); next();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    chk("mid_rst_crstn", {31'd0, crstn}, 32'd0);
    next();
    rst = 1'b0;
    #1;
    wait_crst(n);
    chk("mid_rst_crst_len", n, 32'd2);
    chk("mid_rst_cyc", cyc_count, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd1);
    exp_cyc = 0;
  endtask

  initial begin
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 3'd0;
    host_if.cmd_arg   = '0;
    host_if.bus_req   = 1'b0;
    test_reset();
    test_runn();
    test_step();
    test_brk();
    test_bus();
    test_reset_cmd();
    exp_q.push_back(3);
    issue(3'd5, 16'd3);
    run_and_check("runn_after_reset", 0, 0, 0);
    test_rst_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
